// File: rtl/riscv_hazard_pkg.sv
// Shared types for the forwarding/hazard unit: operand-mux select codes,
// the per-stage destination-register record and the x0 constant.
package riscv_hazard_pkg;

    localparam int RF_ADDR_W = 5;

    localparam logic [RF_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } stage_info_t;

    // A stage can feed a source only if it really writes a non-x0 register
    // that the consuming instruction actually reads.
    function automatic logic stage_matches(
        input logic                 valid,
        input logic                 reg_write,
        input logic [RF_ADDR_W-1:0] rd,
        input logic [RF_ADDR_W-1:0] src,
        input logic                 use_src
    );
        return valid && reg_write && (rd != REG_X0) && (rd == src) && use_src;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline-stage record; resets to an invalid (bubble) entry.
module hazard_stage_reg
    import riscv_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  stage_info_t d,
    output stage_info_t q
);

    // Advance the record every cycle; an asynchronous reset empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage core.
// Shadows the rd state of EX/MEM/WB, registers the ALU operand mux selects
// for the instruction entering EX, and raises a one-cycle load-use stall.
// Optional: define HAZARD_PERF_CNT_EN to add stall/forward event counters.
module fwd_hazard_unit
    import riscv_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  stall_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           fwd_cnt_o,
`endif
    output logic                  bubble_o
);

    stage_info_t ex_q, mem_q, wb_q, ex_d;

    logic [REG_ADDR_W-1:0] src_addr [NUM_SRC];
    logic                  src_use  [NUM_SRC];
    fwd_sel_t              sel_d    [NUM_SRC];
    fwd_sel_t              sel_q    [NUM_SRC];

    logic ex_bubble;
    logic load_hit;

    assign src_addr[0] = id_rs1_i;
    assign src_addr[1] = id_rs2_i;
    assign src_use[0]  = id_use_rs1_i;
    assign src_use[1]  = id_use_rs2_i;

    // Load-use detection: a load in EX whose rd is read by the ID instruction.
    // A flush outranks the stall since the consumer is being discarded anyway.
    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_use[i] && (ex_q.rd == src_addr[i])) begin
                load_hit = 1'b1;
            end
        end
        stall_o = id_valid_i && !flush_i && ex_q.valid && ex_q.mem_read &&
                  (ex_q.rd != REG_X0) && load_hit;
    end

    assign ex_bubble = stall_o || flush_i || !id_valid_i;

    // Build the record that enters EX: either the ID instruction or a bubble.
    always_comb begin
        ex_d = '0;
        if (!ex_bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd_i;
            ex_d.reg_write = id_reg_write_i;
            ex_d.mem_read  = id_mem_read_i;
        end
    end

    // Pick each operand's source; the EX producer is youngest so it wins.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_d[i] = FWD_RF;
            if (!ex_bubble) begin
                if (stage_matches(ex_q.valid, ex_q.reg_write, ex_q.rd,
                                  src_addr[i], src_use[i])) begin
                    sel_d[i] = FWD_MEM;
                end else if (stage_matches(mem_q.valid, mem_q.reg_write, mem_q.rd,
                                           src_addr[i], src_use[i])) begin
                    sel_d[i] = FWD_WB;
                end
            end
        end
    end

    // Register the selects so they line up with the instruction now in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                sel_q[i] <= FWD_RF;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                sel_q[i] <= sel_d[i];
            end
        end
    end

    hazard_stage_reg u_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ex_d),
        .q     (ex_q)
    );

    hazard_stage_reg u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ex_q),
        .q     (mem_q)
    );

    hazard_stage_reg u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mem_q),
        .q     (wb_q)
    );

    assign fwd_a_o  = sel_q[0];
    assign fwd_b_o  = sel_q[1];
    assign bubble_o = !ex_q.valid;

    // The WB record mirrors the real pipeline but no current decision reads it,
    // and a load's mem_read flag stops mattering once it leaves EX.
    logic unused_state;
    assign unused_state = ^{wb_q, mem_q.mem_read};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, fwd_cnt_q;

    // Count stall cycles and edges that load any non-register-file select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((sel_d[0] != FWD_RF) || (sel_d[1] != FWD_RF)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule
